// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin decode arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, GRANT, RELEASE)
//   N_REQ       : number of requesters / decoder outputs
//   IDX_W       : width of the decoder select index
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; same function as the downstream
// decoder the arbiter drives, so gnt always mirrors what that decoder sees.
// Ports:
//   idx    in  [IDX_W-1:0] : select index
//   en     in  1           : enable; all outputs low when clear
//   onehot out [N_REQ-1:0] : en ? (1 << idx) : 0
module onehot_dec3
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoded resource among eight
// requesters. A grant is held until the owner signals done, drops its
// request, or reaches the hold limit; one RELEASE cycle with the decoder
// disabled separates consecutive grants.
// Ports:
//   clk       in  1 : clock, rising edge
//   rst_n     in  1 : asynchronous active-low reset
//   req       in  8 : level-sensitive request lines
//   done      in  1 : owner releases the resource (looked at only in GRANT)
//   gnt_idx   out 3 : decoder select index (current / last owner)
//   gnt_en    out 1 : decoder enable, high only in GRANT
//   gnt       out 8 : one-hot grant, gnt_en ? (1 << gnt_idx) : 0
//   busy      out 1 : high in GRANT and RELEASE
//   timeout   out 1 : one-cycle pulse, high during the RELEASE cycle that
//                     follows a hold-limit release
//   dbg_state out 2 : FSM state, for observation only
//   dbg_ptr   out 3 : round-robin search start, for observation only
//
// Handshake: a requester holds req[i] high until it is granted and for as
// long as it wants the resource; dropping it while granted is an implicit
// release. done is a single-cycle level that only the owner drives, and it
// is meaningful only while gnt_en is high.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_en,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout,
  output arb_state_t       dbg_state,
  output logic [IDX_W-1:0] dbg_ptr
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic             found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_drop;
  logic             at_limit;

  // First set request scanning ptr, ptr+1, ... ; the 3-bit add wraps 7->0.
  always_comb begin
    found    = 1'b0;
    pick_idx = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[ptr_q + IDX_W'(i)]) begin
        found    = 1'b1;
        pick_idx = ptr_q + IDX_W'(i);
      end
    end
  end

  assign owner_drop = !req[gnt_idx_q];
  assign at_limit   = (hold_cnt_q == HOLD_MAX);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_idx_d  = pick_idx;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (!at_limit) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        if (done || owner_drop || at_limit) begin
          state_d   = RELEASE;
          // An explicit release wins over the hold limit: no pulse then.
          timeout_d = at_limit && !done && !owner_drop;
        end
      end
      RELEASE: begin
        // The owner just released becomes lowest priority next round.
        ptr_d   = gnt_idx_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs depend on registered state only; an async reset clears the
  // state register and therefore gnt_en/gnt at once.
  assign gnt_en    = (state_q == GRANT);
  assign busy      = (state_q != IDLE);
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

  onehot_dec3 u_dec (
    .idx    (gnt_idx_q),
    .en     (gnt_en),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
module tb_rr_decode_arbiter;
  import rr_arb_pkg::*;

  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic       done  = 1'b0;

  logic [2:0] gnt_idx;
  logic       gnt_en;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;
  arb_state_t dbg_state;
  logic [2:0] dbg_ptr;

  always #5 clk = ~clk;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_en    (gnt_en),
    .gnt       (gnt),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic       prev_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 granted, 2 dead cycle. held = grant cycles already
  // completed before the current one.
  int m_phase, m_owner, m_ptr, m_held;
  bit m_to;

  // Winner = set request with the smallest circular distance from ptr.
  function automatic int pick(input logic [7:0] r, input int p);
    int best, bestd, d;
    best = -1; bestd = 99;
    for (int i = 0; i < 8; i++) begin
      if (r[i]) begin
        d = (i - p + 8) % 8;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
    exp_q.delete();
    prev_en = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    m_to = 0;
    if (m_phase == 0) begin
      if (r != 8'h00) begin
        m_owner = pick(r, m_ptr);
        m_held  = 0;
        m_phase = 1;
        exp_q.push_back(3'(m_owner));
      end
    end else if (m_phase == 1) begin
      if (d || !r[m_owner] || m_held == MAX_HOLD) begin
        m_to    = (m_held == MAX_HOLD) && !d && r[m_owner];
        m_phase = 2;
      end else begin
        m_held++;
      end
    end else begin
      m_ptr   = (m_owner + 1) % 8;
      m_phase = 0;
    end
  endtask

  function automatic logic [18:0] dut_outs();
    return {dbg_state, gnt_en, gnt_idx, gnt, busy, timeout, dbg_ptr};
  endfunction

  function automatic logic [18:0] model_outs();
    logic [7:0] oh;
    oh = (m_phase == 1) ? (8'd1 << m_owner) : 8'd0;
    return {2'(m_phase), m_phase == 1, 3'(m_owner), oh, m_phase != 0, m_to, 3'(m_ptr)};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, let one rising edge happen, compare
  // on the following negedge.
  task automatic cycle(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    check("model_outs", 32'(dut_outs()), 32'(model_outs()));
    check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
    if (gnt_en && !prev_en) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_order got=%0d exp=none", gnt_idx);
      end else begin
        check("grant_order", 32'(gnt_idx), 32'(exp_q.pop_front()));
      end
    end
    prev_en = gnt_en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("reset_outs", 32'(dut_outs()), 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] idx;
    logic [7:0] gnt;
    logic       busy;
    logic       to;
    logic [2:0] ptr;
  } vec_t;

  vec_t tbl[28];

  function automatic logic [18:0] vec_exp(input vec_t v);
    logic [1:0] st;
    st = v.en ? 2'd1 : (v.busy ? 2'd2 : 2'd0);
    return {st, v.en, v.idx, v.gnt, v.busy, v.to, v.ptr};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         got_idx[$];
    int         got_cyc[$];
    logic [7:0] r;
    logic       d;

    // single requester, done after 3 grant cycles
    tbl[0]  = '{8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{8'h04, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{8'h04, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd3};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd3};
    // timeout: 5 grant cycles, pulse in RELEASE, re-grant to 7
    tbl[6]  = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd3};
    tbl[7]  = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd3};
    tbl[8]  = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd3};
    tbl[9]  = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd3};
    tbl[10] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd3};
    tbl[11] = '{8'h80, 1'b0, 1'b0, 3'd7, 8'h00, 1'b1, 1'b1, 3'd3};
    tbl[12] = '{8'h80, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0};
    // done together with hold limit: no pulse
    tbl[13] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd0};
    tbl[14] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd0};
    tbl[15] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd0};
    tbl[16] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd0};
    tbl[17] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 3'd0};
    tbl[18] = '{8'h80, 1'b1, 1'b0, 3'd7, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[19] = '{8'h00, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 3'd0};
    // owner 5 drops its request, 1 pending; search wraps 6,7,0,1
    tbl[20] = '{8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0, 3'd0};
    tbl[21] = '{8'h22, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1, 1'b0, 3'd0};
    tbl[22] = '{8'h02, 1'b0, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd0};
    tbl[23] = '{8'h02, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 3'd6};
    tbl[24] = '{8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b1, 1'b0, 3'd6};
    tbl[25] = '{8'h02, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 3'd6};
    tbl[26] = '{8'h00, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd2};
    // done outside GRANT is ignored
    tbl[27] = '{8'h00, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd2};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 28; i++) begin
      cycle(tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vec_exp(tbl[i])));
    end

    // round-robin rotation with done held high: order 0..7,0, period 3
    do_reset();
    for (int c = 0; c < 26; c++) begin
      cycle(8'hFF, 1'b1);
      if (gnt_en) begin
        got_idx.push_back(int'(gnt_idx));
        got_cyc.push_back(c);
      end
    end
    check("rot_count", 32'(got_idx.size()), 32'd9);
    for (int k = 0; k < got_idx.size() && k < 9; k++) begin
      check($sformatf("rot_idx%0d", k), 32'(got_idx[k]), 32'(k % 8));
      if (k > 0) check($sformatf("rot_period%0d", k), 32'(got_cyc[k] - got_cyc[k-1]), 32'd3);
    end

    // async reset mid-grant
    do_reset();
    cycle(8'h10, 1'b0);
    check("pre_rst_gnt", 32'(gnt), 32'h10);
    cycle(8'h10, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outs", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'h11, 1'b0);
    check("post_rst_idx", 32'(gnt_idx), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'h01);

    // randomized traffic against the model
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      d = ($urandom_range(0, 7) == 0);
      cycle(r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Round-robin arbiter sharing one 3-to-8 decoded resource among eight requesters. It selects a requester, holds its grant until release or timeout, and inserts one dead cycle between grants so two decoder outputs are never active together. It sits in front of the 3-to-8 decoder path and drives the decoder's select index and enable.

## Interface
Parameters:
- `MAX_HOLD`, default 15: maximum grant cycles before a forced release. Legal range 1..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy `2**CNT_W > MAX_HOLD`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 8: request lines; bit i is requester i. Level-sensitive.
- `done`, in, 1: the current owner releases the resource. Sampled only in GRANT.
- `gnt_idx`, out, 3: index of the current owner (decoder select input).
- `gnt_en`, out, 1: decoder enable; high only in GRANT.
- `gnt`, out, 8: one-hot grant, equal to `gnt_en ? (1 << gnt_idx) : 0`.
- `busy`, out, 1: high in GRANT and RELEASE.
- `timeout`, out, 1: one-cycle pulse when a grant is force-released.

## Operation
- State machine has three states: IDLE, GRANT, RELEASE.
- Registered state: `state`, `ptr[2:0]` (search start), `gnt_idx`, `hold_cnt`.
- IDLE:
  - If `req != 0`, pick the first set bit scanning `ptr, ptr+1, …` with wrap modulo 8.
  - Load `gnt_idx`, clear `hold_cnt`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `gnt_en = 1`; `hold_cnt` increments each cycle and saturates at `MAX_HOLD`.
  - Exit to RELEASE when `done`, when `req[gnt_idx] == 0`, or when `hold_cnt == MAX_HOLD`, whichever comes first.
  - Otherwise stay in GRANT.
- Release priority: `done` or request drop beats timeout. If `done` and the timeout condition occur in the same cycle, there is no `timeout` pulse.
- `timeout` is asserted in the cycle GRANT exits because of the hold limit only.
- RELEASE:
  - Lasts exactly one cycle with `gnt_en = 0` and `gnt = 0`. `gnt_idx` holds its last value.
  - Sets `ptr <= gnt_idx + 1`, wrapping 7 to 0, then goes to IDLE.
- Fairness: the owner just released has the lowest priority in the next arbitration. Any requester that holds its request is granted within 7 other grants.
- `req` changes outside IDLE have no effect except the owner's own bit in GRANT.
- A `done` asserted outside GRANT is ignored.

## Timing
- Reset values: `state` = IDLE, `ptr` = 0, `gnt_idx` = 0, `hold_cnt` = 0, `gnt_en` = 0, `gnt` = 0, `busy` = 0, `timeout` = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req` or `done` to any output.
- Grant latency: `req` sampled high in IDLE at edge N gives `gnt_en = 1` after edge N, i.e. 1 cycle.
- Release latency: `done` sampled at edge M gives `gnt_en = 0` after edge M. The earliest next grant appears after edge M+2.
- Minimum grant length is 1 cycle. Maximum is `MAX_HOLD + 1` cycles.
- Back-to-back period with continuous requests and immediate `done`: 3 cycles per grant (GRANT, RELEASE, IDLE).
- Reset asserted mid-grant forces `gnt_en` and `gnt` to 0 immediately (asynchronously) and returns `ptr` to 0.
- The first edge after `rst_n` rises behaves as a normal IDLE cycle.

## Structure
- Shared package `rr_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2);
  - constants `N_REQ = 8` and `IDX_W = 3`.
- One sub-module, `onehot_dec3`: a 3-bit index plus enable in, 8-bit one-hot out. It produces `gnt` and matches the downstream decoder's function.
- The round-robin priority search, FSM, and counters stay in the top module.

## Test plan
- Single requester: after reset, `req = 8'h04`; `done` after 3 grant cycles. Expect `gnt_idx = 2`, `gnt = 8'h04` one cycle after `req`, high for 3 cycles, then `gnt = 0` for one cycle, `ptr = 3`.
- Round-robin rotation: `req = 8'hFF` held, `done` pulsed each grant. Expect grant order 0,1,2,…,7,0 and `gnt` never two bits set.
- Timeout: `MAX_HOLD = 4`, `req = 8'h80` held, no `done`. Expect `gnt = 8'h80` for 5 cycles, a `timeout` pulse on the exit cycle, RELEASE, then a re-grant to 7 (sole requester).
- Simultaneous `done` and hold limit: expect release with `timeout = 0`.
- Request drop: owner 5 drops `req[5]` mid-grant while `req[1]` is pending. Expect RELEASE next cycle, then `gnt_idx = 1` after IDLE, with `ptr` wrap 6 to 7 to 0 to 1 exercised.
- Async reset mid-grant: pull `rst_n` low between edges while `gnt = 8'h10`. Expect all outputs 0 immediately; after release, `req = 8'h11` grants index 0.
